// File: rtl/display_pkg.sv
// Shared definitions for the display timer and its input-capture counterpart.
package display_pkg;

   localparam int TMR_W = 24;

   typedef enum logic [1:0] {
      SEEK = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } cap_state_e;

   function automatic logic state_is_busy(input cap_state_e st);
      return (st == HIGH) || (st == LOW);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rise/fall detection for an asynchronous level input.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic       meta_q;
   logic       sync_q;
   logic       dly_q;
   logic [2:0] vld_q;

   // vld_q tracks which pipeline stages hold real samples rather than reset zeros,
   // so an input already high at reset release is not mistaken for a rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
         vld_q  <= 3'b000;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
         vld_q  <= {vld_q[1:0], 1'b1};
      end
   end

   assign level_o = sync_q;
   assign rise_o  = vld_q[2] &  sync_q & ~dly_q;
   assign fall_o  = vld_q[2] & ~sync_q &  dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform, one result per
// rising-to-rising cycle; aborts with an overflow pulse when no edge arrives in time.
module pwm_capture
   import display_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         sig_in,
   output logic [W-1:0] cap_period,
   output logic [W-1:0] cap_compare,
   output logic         cap_valid,
   output logic         ovf,
   output logic         busy
);

   localparam logic [W-1:0] CNT_ONE = W'(1);
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic sig_level;
   logic sig_rise;
   logic sig_fall;

   sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (sig_in),
      .level_o (sig_level),
      .rise_o  (sig_rise),
      .fall_o  (sig_fall)
   );

   cap_state_e   state_q;
   logic [W-1:0] cnt_q;
   logic [W-1:0] high_cnt_q;
   logic [W-1:0] cap_period_q;
   logic [W-1:0] cap_compare_q;
   logic         cap_valid_q;
   logic         ovf_q;
   logic         busy_q;

   logic [W-1:0] cnt_d;
   logic         cnt_at_max;

   assign cnt_d      = cnt_q + CNT_ONE;
   assign cnt_at_max = (cnt_q == CNT_MAX);

   // An edge arriving on the same cycle the counter saturates takes priority over overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= SEEK;
         cnt_q         <= '0;
         high_cnt_q    <= '0;
         cap_period_q  <= '0;
         cap_compare_q <= '0;
         cap_valid_q   <= 1'b0;
         ovf_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         cap_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         if (!en) begin
            state_q <= SEEK;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               SEEK: begin
                  if (sig_rise) begin
                     state_q <= HIGH;
                     cnt_q   <= CNT_ONE;
                     busy_q  <= 1'b1;
                  end
               end
               HIGH: begin
                  if (sig_fall) begin
                     state_q    <= LOW;
                     high_cnt_q <= cnt_q;
                     cnt_q      <= cnt_d;
                  end else if (cnt_at_max) begin
                     state_q <= SEEK;
                     cnt_q   <= '0;
                     ovf_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               LOW: begin
                  if (sig_rise) begin
                     state_q       <= HIGH;
                     cap_period_q  <= cnt_q;
                     cap_compare_q <= high_cnt_q;
                     cap_valid_q   <= 1'b1;
                     cnt_q         <= CNT_ONE;
                  end else if (cnt_at_max) begin
                     state_q <= SEEK;
                     cnt_q   <= '0;
                     ovf_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               default: begin
                  state_q <= SEEK;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cap_period  = cap_period_q;
   assign cap_compare = cap_compare_q;
   assign cap_valid   = cap_valid_q;
   assign ovf         = ovf_q;
   assign busy        = busy_q;

   logic unused_ok;
   assign unused_ok = sig_level ^ state_is_busy(state_q);

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with W=4: directed PWM waveforms, hand-computed results.
`timescale 1ns/1ps
module tb_pwm_capture;

   localparam int W   = 4;
   localparam int MAX = 15;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         sig_in;
   logic [W-1:0] cap_period;
   logic [W-1:0] cap_compare;
   logic         cap_valid;
   logic         ovf;
   logic         busy;

   pwm_capture #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sig_in      (sig_in),
      .cap_period  (cap_period),
      .cap_compare (cap_compare),
      .cap_valid   (cap_valid),
      .ovf         (ovf),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_ovf;
      int period;
      int compare;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   total = 0;
   int   bad   = 0;
   int   cyc_cnt = 0;
   int   last_start = 0;
   bit   busy_prev = 1'b0;

   int   prev_h = 0;
   int   prev_l = 0;
   bit   prev_valid = 1'b0;

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic push_cap(input int p, input int c);
      exp_t e;
      e.is_ovf = 1'b0; e.period = p; e.compare = c;
      exp_q.push_back(e);
   endtask

   task automatic push_ovf();
      exp_t e;
      e.is_ovf = 1'b1; e.period = 0; e.compare = 0;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic lvl, input int n);
      sig_in = lvl;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One PWM cycle; its rising edge closes the previous cycle (capture or overflow).
   task automatic cyc(input int h, input int l);
      if (prev_valid) begin
         if (prev_h + prev_l <= MAX) push_cap(prev_h + prev_l, prev_h);
         else                        push_ovf();
      end
      drive(1'b1, h);
      drive(1'b0, l);
      prev_h = h;
      prev_l = l;
      prev_valid = 1'b1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports a result.
   always @(negedge clk) begin
      cyc_cnt++;
      if (cap_valid && ovf) begin
         total++; bad++;
         $display("FAIL both_pulses cap_valid=%0b ovf=%0b want never both", cap_valid, ovf);
      end
      if (cap_valid || ovf) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cap_valid=%0b ovf=%0b period=%0d compare=%0d want none",
                     cap_valid, ovf, cap_period, cap_compare);
         end else begin
            cur = exp_q.pop_front();
            if (cur.is_ovf) begin
               if (!ovf || (cyc_cnt - last_start) != MAX) begin
                  bad++;
                  $display("FAIL ovf_event got ovf=%0b gap=%0d want ovf=1 gap=%0d",
                           ovf, cyc_cnt - last_start, MAX);
               end else begin
                  $display("ovf  gap=%0d", cyc_cnt - last_start);
               end
            end else begin
               if (!cap_valid || cap_period != W'(cur.period) || cap_compare != W'(cur.compare)) begin
                  bad++;
                  $display("FAIL cap_event got valid=%0b period=%0d compare=%0d want valid=1 period=%0d compare=%0d",
                           cap_valid, cap_period, cap_compare, cur.period, cur.compare);
               end else begin
                  $display("cap  period=%0d compare=%0d", cap_period, cap_compare);
               end
            end
         end
      end
      if (cap_valid || (busy && !busy_prev)) last_start = cyc_cnt;
      busy_prev = busy;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en = 1'b1; sig_in = 1'b0;
      // Reset held while the input toggles: every output stays zero.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         sig_in = ~sig_in;
         @(negedge clk);
         check("reset_outputs", {cap_period, cap_compare, cap_valid, ovf, busy}, 0);
      end
      @(posedge clk); #1;
      sig_in = 1'b1;
      rst = 1'b1;
      // High level at release is not a rise; first period starts at the next 0->1.
      drive(1'b1, 3);
      drive(1'b0, 3);
      check("seek_after_release_busy", busy, 0);

      for (int i = 0; i < 5; i++) cyc(4, 3);
      for (int i = 0; i < 2; i++) cyc(1, 6);
      for (int i = 0; i < 2; i++) cyc(7, 1);

      // Enable dropped while the DUT is in LOW: that period is lost.
      if (prev_valid) push_cap(prev_h + prev_l, prev_h);
      drive(1'b1, 4);
      drive(1'b0, 4);
      check("busy_before_en_drop", busy, 1);
      en = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("busy_en_low", busy, 0);
      drive(1'b0, 2);
      en = 1'b1;
      drive(1'b0, 3);
      prev_valid = 1'b0;
      cyc(4, 3);
      cyc(2, 5);

      // Constant low after a rise -> overflow; results keep the last capture.
      push_cap(prev_h + prev_l, prev_h);
      push_ovf();
      drive(1'b1, 4);
      drive(1'b0, 22);
      check("ovf_low_busy", busy, 0);
      check("ovf_low_period_hold", cap_period, 7);
      check("ovf_low_compare_hold", cap_compare, 2);
      // Constant high -> overflow with the same timing.
      push_ovf();
      drive(1'b1, 22);
      check("ovf_high_busy", busy, 0);
      check("ovf_high_period_hold", cap_period, 7);
      check("ovf_high_compare_hold", cap_compare, 2);
      drive(1'b0, 3);
      prev_valid = 1'b0;

      // Boundary: period 15 captures, period 16 overflows; then minimum 1/1 pulses.
      cyc(5, 10);
      cyc(5, 10);
      cyc(5, 11);
      cyc(1, 1);
      cyc(1, 1);
      cyc(3, 3);
      push_cap(prev_h + prev_l, prev_h);
      drive(1'b1, 2);
      drive(1'b0, 8);
      check("last_period", cap_period, 6);
      check("last_compare", cap_compare, 3);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
